seq_bcd_converter: RTL
======================

// Module: seq_bcd_converter
// PURPOSE
//  Iterative, parametrised binary-to-BCD converter using shift-and-add-3, one bit per clock.
//  Successor to the combinational 8-bit converter: any WIDTH, valid/ready handshakes, registered output,
//  and a leading-zero mask for display blanking. Sits between the timer counters and the 7-segment decoders.
// PARAMETERS
//  WIDTH   16  binary input width, >= 1
//  DIGITS  5   BCD output digits; must satisfy 10**DIGITS > 2**WIDTH-1, otherwise $error at elaboration
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   1         bin is valid
//  in_ready   out  1         converter can accept bin
//  bin        in   WIDTH     unsigned binary operand
//  out_valid  out  1         bcd/digit_nz are valid
//  out_ready  in   1         consumer accepts result
//  bcd        out  4*DIGITS  packed BCD; digit 0 = bcd[3:0] (units)
//  digit_nz   out  DIGITS    bit i=1 if digit i or any higher digit is nonzero; bit 0 always 1
// BEHAVIOUR
//  Reset: async on rst_n low -> state IDLE; out_valid=0, bcd=0, digit_nz=0, bit counter=0, shift regs=0.
//   Reset low mid-conversion aborts it; no result is produced; in_ready=1 on the first edge after release.
//  FSM states IDLE, SHIFT, DONE.
//   IDLE:  in_ready=1. On in_valid&&in_ready: load shift reg {DIGITS*4'b0, bin}, cnt=0 -> SHIFT.
//   SHIFT: in_ready=0. Each cycle: every BCD digit >= 5 gets +3, then whole reg shifts left 1; cnt++.
//          When cnt==WIDTH-1 (last shift this edge) -> DONE; bcd and digit_nz registered from post-shift value.
//   DONE:  out_valid=1; bcd/digit_nz held stable until out_ready.
//          out_ready=1, in_valid=0 -> IDLE, out_valid=0 next edge.
//          out_ready=1, in_valid=1 -> in_ready=1 (combinational from state&&out_ready); new operand loaded -> SHIFT.
//          out_ready=0 -> stay; in_ready=0; input ignored.
//  Latency: accept at edge t -> out_valid high after edge t+WIDTH. Throughput: one result per WIDTH+1 cycles.
//  in_ready = (state==IDLE) || (state==DONE && out_ready). No combinational path from in_valid to outputs.
//  Arithmetic: digits are 4-bit, add-3 only when value >= 5, never overflows given the DIGITS constraint.
//   Result = exact decimal of bin; unused high digits are 0.
//  digit_nz is computed from the final digits and registered with bcd.
//  bin is sampled only on the accepting edge; changes during SHIFT have no effect.
//  WIDTH==1: single SHIFT cycle; the same rules apply.
// STRUCTURE
//  Package bcd_pkg: state enum/localparams (IDLE/SHIFT/DONE), function min_bcd_digits(width) used by the DIGITS check.
//  Sub-module bcd_digit_adj: combinational 4-bit add-3-if->=5 cell, instantiated DIGITS times in a generate loop.
//  Top: FSM, $clog2(WIDTH)-bit counter, (4*DIGITS+WIDTH)-bit shift register, output registers.
// TESTING
//  WIDTH=8,DIGITS=3: bin=255 accepted at edge 0 -> out_valid after edge 8, bcd=12'h255, digit_nz=3'b111.
//  WIDTH=16,DIGITS=5: bin=0 -> bcd=20'h00000, digit_nz=5'b00001; bin=65535 -> bcd=20'h65535, digit_nz=5'b11111.
//  Backpressure: out_ready=0 for 10 cycles in DONE -> bcd stable, in_ready=0, in_valid pulses ignored.
//  Back-to-back: out_ready=1, in_valid=1 in DONE (bins 9 then 10) -> 20'h00009 then 20'h00010, WIDTH+1 cycles apart.
//  Reset: rst_n low at SHIFT cycle 5 -> out_valid=0, bcd=0 immediately; no stale result after release.
//  Random: 10k random bins at WIDTH 8/12/16 vs scoreboard conversion; DIGITS=4,WIDTH=16 -> elaboration error.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
// Latency/backpressure: not applicable (types and constant functions only).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits of 2**width-1 equal floor(width*log10(2))+1, since 2**width is never a power of ten.
    function automatic int min_bcd_digits(input int width);
        longint scaled;
        scaled = (longint'(width) * 64'sd30103) / 64'sd100000;
        return int'(scaled) + 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the shift.
// Purely combinational, no latency, no flow control.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seq_bcd_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one operand bit per clock) with leading-zero mask.
// Latency WIDTH cycles accept-to-out_valid; result held until out_ready, new input stalled meanwhile.
module seq_bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]   digit_nz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;

    if (WIDTH < 1) begin : g_width_check
        $error("seq_bcd_converter: WIDTH must be at least 1");
    end

    if (DIGITS < min_bcd_digits(WIDTH)) begin : g_digits_check
        $error("seq_bcd_converter: DIGITS too small to hold 2**WIDTH-1");
    end

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     sreg;
    logic [BW-1:0]     adj_digits;
    logic [SW-1:0]     pre_shift;
    logic [SW-1:0]     shifted;
    logic [DIGITS-1:0] final_nz;
    logic              accept;
    logic              last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (sreg[WIDTH + 4*i +: 4]),
            .adjusted (adj_digits[4*i +: 4])
        );
    end

    assign pre_shift = {adj_digits, sreg[WIDTH-1:0]};
    assign shifted   = pre_shift << 1;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign accept    = in_valid && in_ready;

    // Running OR from the top digit down gives the blanking mask; units always lit.
    always_comb begin
        logic seen;
        final_nz = '0;
        seen     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (|shifted[WIDTH + 4*i +: 4]);
            final_nz[i] = seen;
        end
        final_nz[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? SHIFT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sreg     <= '0;
            bcd      <= '0;
            digit_nz <= '0;
        end else if (accept) begin
            sreg <= {{BW{1'b0}}, bin};
            cnt  <= '0;
        end else if (state == SHIFT) begin
            sreg <= shifted;
            cnt  <= cnt + CW'(1);
            if (last) begin
                bcd      <= shifted[SW-1:WIDTH];
                digit_nz <= final_nz;
            end
        end
    end

endmodule
